// File: rtl/result_unloader.sv
// Result unloader: latches four 2*W-bit products and drains them as two 4*W-bit beats
// over a valid/ready stream, most-significant product first.
module result_unloader #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic [2*W-1:0]   prod0,
    input  logic [2*W-1:0]   prod1,
    input  logic [2*W-1:0]   prod2,
    input  logic [2*W-1:0]   prod3,
    output logic [4*W-1:0]   out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             ovf,
    input  logic             clr_ovf,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [2*W-1:0] hold0, hold1, hold2, hold3;
    logic           xfer;
    logic           load;
    logic           drop;
    logic           frame_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Outputs decode from state only, so out_ready never reaches out_valid.
    always_comb begin
        state_nx   = state;
        load       = 1'b0;
        drop       = 1'b0;
        frame_done = 1'b0;
        xfer       = (state != IDLE) && out_ready;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                if (capture) begin
                    load     = 1'b1;
                    state_nx = BEAT0;
                end
            end
            BEAT0: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = {hold0, hold1};
                drop      = capture;
                if (xfer) begin
                    state_nx = BEAT1;
                end
            end
            BEAT1: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                busy      = 1'b1;
                out_data  = {hold2, hold3};
                if (xfer) begin
                    frame_done = 1'b1;
                    if (capture) begin
                        load     = 1'b1;
                        state_nx = BEAT0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    drop = capture;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold0 <= '0;
            hold1 <= '0;
            hold2 <= '0;
            hold3 <= '0;
        end else if (load) begin
            hold0 <= prod0;
            hold1 <= prod1;
            hold2 <= prod2;
            hold3 <= prod3;
        end
    end

    // A dropped capture outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_result_unloader.sv
// Scoreboard bench for result_unloader: directed scenarios followed by random traffic,
// checked against a beat-queue reference model.
module tb_result_unloader;

    localparam int W     = 8;
    localparam int CNT_W = 8;

    typedef struct {
        logic [4*W-1:0] d;
        logic           l;
    } beat_t;

    logic             clk;
    logic             rst_n;
    logic             capture;
    logic [2*W-1:0]   prod0, prod1, prod2, prod3;
    logic [4*W-1:0]   out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic             ovf;
    logic             clr_ovf;
    logic [CNT_W-1:0] frame_cnt;

    result_unloader #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (capture),
        .prod0     (prod0),
        .prod1     (prod1),
        .prod2     (prod2),
        .prod3     (prod3),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned fails  = 0;

    // Reference model: beats still owed to the stream, plus sticky flag and frame count.
    beat_t            exp_q[$];
    int               rem     = 0;
    logic             exp_ovf = 1'b0;
    logic [CNT_W-1:0] exp_cnt = '0;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Model step: evaluated mid-cycle on the inputs that the next rising edge will see.
    always @(negedge clk) begin
        logic mxfer, accept, mdrop;
        check("valid", {31'd0, out_valid}, {31'd0, rem != 0});
        check("busy",  {31'd0, busy},      {31'd0, rem != 0});
        check("ovf",   {31'd0, ovf},       {31'd0, exp_ovf});
        check("cnt",   {24'd0, frame_cnt}, {24'd0, exp_cnt});
        if (rst_n) begin
            mxfer  = (rem != 0) && out_ready;
            accept = capture && (rem == 0 || (rem == 1 && mxfer));
            mdrop  = capture && !accept;
            if (mxfer && rem == 1) exp_cnt = exp_cnt + 1'b1;
            if (accept) begin
                rem = 2;
                exp_q.push_back('{d: {prod0, prod1}, l: 1'b0});
                exp_q.push_back('{d: {prod2, prod3}, l: 1'b1});
            end else if (mxfer) begin
                rem = rem - 1;
            end
            if (mdrop) exp_ovf = 1'b1;
            else if (clr_ovf) exp_ovf = 1'b0;
        end
    end

    // Monitor: pops expected beats on each handshake, checks idle zeros and stall stability.
    logic           stalled = 1'b0;
    logic [4*W-1:0] prev_data;
    logic           prev_last;
    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            stalled = 1'b0;
        end else if (out_valid) begin
            if (stalled) begin
                check("stall_data", out_data, prev_data);
                check("stall_last", {31'd0, out_last}, {31'd0, prev_last});
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    fails++;
                    checks++;
                    $display("FAIL unexpected_beat: got data 0x%0h, expected no beat at %0t", out_data, $time);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", out_data, b.d);
                    check("beat_last", {31'd0, out_last}, {31'd0, b.l});
                end
            end
            stalled   = !out_ready;
            prev_data = out_data;
            prev_last = out_last;
        end else begin
            check("idle_data", out_data, 32'd0);
            check("idle_last", {31'd0, out_last}, 32'd0);
            stalled = 1'b0;
        end
    end

    task automatic step(input logic cap, input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                        input logic [2*W-1:0] c, input logic [2*W-1:0] d,
                        input logic rdy, input logic clr);
        capture   = cap;
        prod0     = a;
        prod1     = b;
        prod2     = c;
        prod3     = d;
        out_ready = rdy;
        clr_ovf   = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, rdy, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        capture   = 1'b0;
        prod0     = '0;
        prod1     = '0;
        prod2     = '0;
        prod3     = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", out_data, 32'd0);
        check("rst_cnt", {24'd0, frame_cnt}, 32'd0);
        #1;
        rst_n = 1'b1;

        // Single frame with ready held high.
        step(1'b1, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 1'b1, 1'b0);
        idle(1'b1, 3);
        check("single_cnt", {24'd0, frame_cnt}, 32'd1);

        // Backpressure on the first beat for five cycles.
        step(1'b1, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 1'b0, 1'b0);
        idle(1'b0, 5);
        idle(1'b1, 3);

        // Back-to-back frames: second capture in the BEAT1 handshake cycle.
        step(1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1, 1'b0);
        idle(1'b1, 1);
        step(1'b1, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b1, 1'b0);
        idle(1'b1, 3);

        // Dropped capture in BEAT0 under backpressure, then clear.
        step(1'b1, 16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4, 1'b0, 1'b0);
        step(1'b1, 16'hFFFF, 16'hEEEE, 16'hDDDD, 16'hCCCC, 1'b0, 1'b0);
        idle(1'b0, 1);
        idle(1'b1, 3);
        check("ovf_set", {31'd0, ovf}, 32'd1);
        step(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
        check("ovf_clr", {31'd0, ovf}, 32'd0);

        // Reset while the second beat is held.
        step(1'b1, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 1'b1, 1'b0);
        idle(1'b1, 1);
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        rem     = 0;
        exp_ovf = 1'b0;
        exp_cnt = '0;
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        idle(1'b1, 3);
        check("rst_mid_cnt", {24'd0, frame_cnt}, 32'd0);

        // 256 frames wrap the counter back to zero.
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b0);
            idle(1'b1, 1);
        end
        idle(1'b1, 2);
        check("wrap_cnt", {24'd0, frame_cnt}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 3) == 0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 ($urandom % 4) != 0, ($urandom % 16) == 0);
        end
        for (int i = 0; i < 10 && rem != 0; i++) idle(1'b1, 1);
        check("drained", rem, 32'd0);
        idle(1'b1, 2);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/result_unloader.md
Name: result_unloader

Overview:
- Output-side counterpart to the operand loader in the parallel multiplier.
- Captures the four 2*W-bit products from the multiplier array in one cycle.
- Drains them as packed 32-bit-class words over a valid/ready stream, two beats per frame, most-significant product first.
- Mirrors the loader's byte packing: prod0 takes the upper half of the first beat, as a0 does in the loader.

Parameters:
- W, 8, operand width; each product is 2*W bits and each output beat is 4*W bits.
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- capture  input  1  single-cycle request to latch prod0..prod3.
- prod0  input  2*W  product lane 0.
- prod1  input  2*W  product lane 1.
- prod2  input  2*W  product lane 2.
- prod3  input  2*W  product lane 3.
- out_data  output  4*W  packed output beat.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  downstream accepts the beat.
- out_last  output  1  marks the final beat of a frame.
- busy  output  1  a frame is held or being drained.
- ovf  output  1  sticky flag: a capture was dropped.
- clr_ovf  input  1  synchronous clear of ovf.
- frame_cnt  output  CNT_W  count of completed frames.

Behaviour:
- Reset is asynchronous on the falling edge of rst_n and released synchronously to clk.
  - While rst_n=0: state=IDLE, all four holding registers=0, out_valid=0, out_last=0, out_data=0, busy=0, ovf=0, frame_cnt=0.
  - Reset asserted mid-frame discards the frame; no beats are emitted after release.
- States: IDLE, BEAT0, BEAT1. busy=1 in BEAT0 and BEAT1.
- A handshake ("xfer") occurs on a rising edge where out_valid=1 and out_ready=1.
- IDLE:
  - capture=1 latches prod0..prod3 into the holding registers and moves to BEAT0.
  - out_valid rises on the next cycle, so capture-to-first-beat latency is 1 cycle.
- BEAT0:
  - out_valid=1, out_last=0, out_data={hold0,hold1}.
  - On xfer, move to BEAT1.
- BEAT1:
  - out_valid=1, out_last=1, out_data={hold2,hold3}.
  - On xfer without capture: go to IDLE and increment frame_cnt.
- Back-to-back frames:
  - xfer in BEAT1 with capture=1 in the same cycle latches the new products, goes to BEAT0 and increments frame_cnt.
  - There is no idle bubble between frames.
- Dropped captures:
  - capture=1 in BEAT0, or in BEAT1 without xfer, is ignored.
  - The holding registers stay unchanged and ovf is set to 1.
- ovf behaviour:
  - ovf stays 1 until clr_ovf=1.
  - If clr_ovf and a dropping capture occur in the same cycle, set wins and ovf=1.
- Stream stability:
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - out_valid never deasserts without an xfer.
- out_ready is ignored when out_valid=0.
- When out_valid=0, out_data=0 and out_last=0.
- frame_cnt wraps modulo 2^CNT_W.
- All outputs are registered or decoded from registered state only; there is no combinational path from out_ready to out_valid.

Test Plan:
- Single frame, W=8:
  - Stimulus: prod0..3 = 0x1234, 0x5678, 0x9ABC, 0xDEF0; capture pulse; out_ready held 1.
  - Required response: beat 0x12345678 with out_last=0, then beat 0x9ABCDEF0 with out_last=1 on the next cycle; then out_valid=0, busy=0, frame_cnt=1.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after capture.
  - Required response: out_data holds 0x12345678 with out_valid=1 throughout; no beat is lost after out_ready rises.
- Back-to-back frames:
  - Stimulus: a second capture (0x0001, 0x0002, 0x0003, 0x0004) asserted in the BEAT1 xfer cycle.
  - Required response: next beat is 0x00010002 with no idle cycle between frames; frame_cnt=2 after both frames.
- Overflow:
  - Stimulus: capture with different products while in BEAT0 under out_ready=0.
  - Required response: ovf=1 and the original data is emitted unchanged.
  - Stimulus: clr_ovf pulse. Required response: ovf=0.
- Reset mid-frame:
  - Stimulus: rst_n pulled low in BEAT1 with no clk edge during the low period.
  - Required response: out_valid=0 and busy=0 immediately; no beat is emitted after release; frame_cnt=0.
- Counter wrap:
  - Stimulus: 256 frames with CNT_W=8.
  - Required response: frame_cnt=0 after the 256th frame completes.
